// File: rtl/locker_pkg.sv
// Shared types and constants for the locker session controller.
// The state encoding doubles as the status code shown on the display.
package locker_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'b00,
    OPEN    = 2'b01,
    MASTER  = 2'b10,
    PENALTY = 2'b11
  } state_e;

  localparam logic [1:0] Y_LOCKED  = 2'b00;
  localparam logic [1:0] Y_OPEN    = 2'b01;
  localparam logic [1:0] Y_MASTER  = 2'b10;
  localparam logic [1:0] Y_PENALTY = 2'b11;

  localparam logic [7:0] DEF_USER_PIN   = 8'h03;
  localparam logic [7:0] DEF_MASTER_PIN = 8'h80;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/locker_access_ctrl_if.sv
// Keypad-side and display-side signals of the locker controller.
interface locker_access_ctrl_if;
  logic [1:0] req;
  logic [7:0] pin0;
  logic [7:0] pin1;
  logic [1:0] gnt;
  logic [1:0] y_out;
  logic [1:0] fail_cnt;

  modport master (output req, pin0, pin1, input gnt, y_out, fail_cnt);
  modport slave  (input req, pin0, pin1, output gnt, y_out, fail_cnt);
endinterface

// File: rtl/locker_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves away from whoever was granted.
module locker_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
      else                gnt_o = req_i;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0])      ptr_d = 1'b1;
    else if (gnt_o[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/locker_access_ctrl.sv
// Locker session FSM: PIN judging, wrong-attempt counting, master escalation,
// penalty lockout and timed open window sharing one down-counter.
module locker_access_ctrl
  import locker_pkg::*;
#(
  parameter logic [7:0] USER_PIN       = DEF_USER_PIN,
  parameter logic [7:0] MASTER_PIN     = DEF_MASTER_PIN,
  parameter int         MAX_TRIES      = 3,
  parameter int         OPEN_CYCLES    = 8,
  parameter int         PENALTY_CYCLES = 16
) (
  input logic                 clock,
  input logic                 reset,
  locker_access_ctrl_if.slave bus
);
  localparam int TW = $clog2(max_int(OPEN_CYCLES, PENALTY_CYCLES)) + 1;
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0] PEN_LOAD  = TW'(PENALTY_CYCLES);
  localparam logic [1:0]    MAX_CNT   = 2'(MAX_TRIES);

  state_e        state_q, state_d;
  logic [1:0]    fail_q, fail_d, fail_inc;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    gnt;
  logic [7:0]    pin_sel;
  logic          arb_en, granted, pin_user, pin_master;

  // Grants are masked during reset so a held request cannot slip through.
  assign arb_en = ~reset & ((state_q == LOCKED) || (state_q == MASTER));

  locker_rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .en_i  (arb_en),
    .req_i (bus.req),
    .gnt_o (gnt)
  );

  assign granted    = |gnt;
  assign pin_sel    = gnt[1] ? bus.pin1 : bus.pin0;
  assign pin_user   = (pin_sel == USER_PIN);
  assign pin_master = (pin_sel == MASTER_PIN);
  assign fail_inc   = (fail_q == MAX_CNT) ? fail_q : fail_q + 2'd1;

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    case (state_q)
      LOCKED: begin
        if (granted) begin
          if (pin_user || pin_master) begin
            state_d = OPEN;
            fail_d  = 2'd0;
            timer_d = OPEN_LOAD;
          end else begin
            fail_d = fail_inc;
            if (fail_inc == MAX_CNT) state_d = MASTER;
          end
        end
      end
      MASTER: begin
        if (granted) begin
          if (pin_master) begin
            state_d = OPEN;
            fail_d  = 2'd0;
            timer_d = OPEN_LOAD;
          end else begin
            state_d = PENALTY;
            timer_d = PEN_LOAD;
          end
        end
      end
      OPEN: begin
        if (timer_q <= TW'(1)) begin
          state_d = LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      PENALTY: begin
        if (timer_q <= TW'(1)) begin
          state_d = MASTER;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOCKED;
      fail_q  <= 2'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.y_out    = state_q;
  assign bus.fail_cnt = fail_q;
endmodule

// File: doc/locker_access_ctrl.md
# locker_access_ctrl

Session controller for the digital locker: arbitrates PIN submissions from two keypads onto a single PIN checker, counts wrong attempts, escalates to master-PIN-only mode, enforces a penalty lockout and auto-relocks after a timed open window. It sits between the keypad front-ends and the lock actuator/status display. The 2-bit status code drives the existing locker status display.

## Interface
- `USER_PIN`, 8'h03: user PIN, two BCD digits.
- `MASTER_PIN`, 8'h80: master PIN, two BCD digits.
- `MAX_TRIES`, 3: wrong user attempts before master mode; legal range 1..3.
- `OPEN_CYCLES`, 8: cycles the lock stays open; must be ≥1.
- `PENALTY_CYCLES`, 16: lockout cycles after a wrong master PIN; must be ≥1.

Ports:
- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `req`, input, 2: per-keypad submit request; held until granted.
- `pin0`, input, 8: keypad 0 PIN; stable while `req[0]` is high.
- `pin1`, input, 8: keypad 1 PIN; stable while `req[1]` is high.
- `gnt`, output, 2: one-hot grant; PIN is consumed in the grant cycle.
- `y_out`, output, 2: status. 00 LOCKED, 01 OPEN, 10 MASTER, 11 PENALTY.
- `fail_cnt`, output, 2: current wrong-attempt count.

## Operation
States:
- **LOCKED**: `y_out`=00.
  - Granted PIN == `USER_PIN` or `MASTER_PIN` → OPEN; `fail_cnt` cleared.
  - Any other PIN → `fail_cnt`+1. If the new count equals `MAX_TRIES` → MASTER.
- **MASTER**: `y_out`=10.
  - PIN == `MASTER_PIN` → OPEN; `fail_cnt` cleared.
  - Any other PIN, including `USER_PIN` → PENALTY. `fail_cnt` is held.
- **PENALTY**: `y_out`=11. Lasts exactly `PENALTY_CYCLES` cycles, then → MASTER.
- **OPEN**: `y_out`=01. Lasts exactly `OPEN_CYCLES` cycles, then → LOCKED.

Grant rules:
- Grants are issued only in LOCKED and MASTER. In OPEN and PENALTY, `gnt`=00 and requests wait.
- Round-robin between the two keypads. The priority pointer starts at keypad 0 and moves to the other keypad after every grant.
- With a single requester, that keypad is granted regardless of the pointer.
- `gnt` is combinational from `req`, state and pointer. At most one bit is set.

PIN handling:
- Comparison is an exact 8-bit equality.
- Non-BCD codes (e.g. 8'h3A) are simply wrong PINs; no error flag.

`fail_cnt` saturates at `MAX_TRIES`. It clears only on a successful open or on reset.

## Timing
- Reset values: state LOCKED, `y_out`=00, `fail_cnt`=0, pointer=0, timers=0.
- `gnt`=00 while `reset` is high, even if `req` is asserted.
- Reset asserted mid-OPEN or mid-PENALTY aborts immediately (asynchronous); no timer residue.
- Latency: grant in cycle N; `y_out` and `fail_cnt` reflect the result from the clock edge ending cycle N.
- Back-to-back grants:
  - A grant in cycle N+1 is allowed and is judged against the state updated at the end of N.
  - Example: keypad 0's correct PIN at N opens the lock, so keypad 1's pending request waits until LOCKED is re-entered.
- Requesters drop `req` the cycle after seeing `gnt`. If `req` is still high, it is treated as a new submission.
- OPEN timer: `y_out`=01 for exactly `OPEN_CYCLES` edges; LOCKED is visible on the following edge.
- PENALTY timer: same rule as OPEN, using `PENALTY_CYCLES`.
- Timer width is `$clog2(max(OPEN_CYCLES, PENALTY_CYCLES))`+1 bits. The timer loads on state entry and counts down to 1.

## Structure
- Package `locker_pkg` holds:
  - the state enum (LOCKED, OPEN, MASTER, PENALTY);
  - `y_out` code constants, which equal the state encoding;
  - default PIN constants 8'h03 and 8'h80.
- Sub-module `locker_rr_arb2`: two-requester round-robin arbiter with an enable input (state is LOCKED or MASTER) and a one-hot grant output. It owns the pointer register.
- The top level holds the FSM, `fail_cnt`, the shared timer and the PIN comparators.

## Test plan
- **Reset and wrong attempts**: reset, then keypad 0 submits 8'h29, 8'h26, 8'h10 → `fail_cnt` 1, 2, 3; `y_out` goes 00→10 after the third attempt.
- **Master mode**: in MASTER, submit 8'h03 → `y_out`=11 for 16 cycles, then 10. Submit 8'h80 → `y_out`=01 for 8 cycles, then 00 with `fail_cnt`=0.
- **Arbitration**: both keypads request simultaneously from reset with 8'h92 and 8'h92 → `gnt`=01 then 10 in consecutive cycles; `fail_cnt` goes 1→2.
- **Priority on open**: both request, keypad 0 holds 8'h03 → keypad 0 granted and `y_out`=01. Keypad 1 gets `gnt` only once LOCKED is re-entered, 8 cycles later.
- **Reset mid-open**: assert `reset` during OPEN at cycle 3 → `y_out`=00, `gnt`=00 immediately; after release a correct PIN reopens with a full 8-cycle window.
- **Saturation and non-BCD**: with `MAX_TRIES`=1, submit 8'h3A → MASTER after one attempt, `fail_cnt`=1 and held there.
